// File: rtl/fpacc_pkg.sv
// -----------------------------------------------------------------------------
// fpacc_pkg
//   Shared types and constants for the floating-point accumulator.
//   Contents:
//     state_t        accumulator state (IDLE / ACCUM / DONE)
//     SIGN_MASK      sign bit of an IEEE-754 single
//     EXP_ONES       all-ones exponent (Inf / NaN)
//     fp_sign/exp/mant  field slices of an IEEE-754 single
//     fp_is_special  1 when the exponent field is all ones
// -----------------------------------------------------------------------------
package fpacc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,   // no element accepted yet
    ACCUM = 2'd1,   // partial sum held in the accumulator
    DONE  = 2'd2    // result held, waiting for the consumer
  } state_t;

  localparam logic [31:0] SIGN_MASK = 32'h8000_0000;
  localparam logic [7:0]  EXP_ONES  = 8'hFF;

  function automatic logic fp_sign(input logic [31:0] value);
    return value[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] value);
    return value[30:23];
  endfunction

  function automatic logic [22:0] fp_mant(input logic [31:0] value);
    return value[22:0];
  endfunction

  function automatic logic fp_is_special(input logic [31:0] value);
    return fp_exp(value) == EXP_ONES;
  endfunction

endpackage

// File: rtl/fpacc_exc_det.sv
// -----------------------------------------------------------------------------
// fpacc_exc_det
//   Combinational Inf/NaN detector for one IEEE-754 single value.
//   Ports:
//     value   in  32  operand to inspect
//     is_exc  out 1   exponent field is all ones (Inf or NaN)
// -----------------------------------------------------------------------------
module fpacc_exc_det
  import fpacc_pkg::*;
(
  input  logic [31:0] value,
  output logic        is_exc
);

  assign is_exc = fp_is_special(value);

endmodule

// File: rtl/fp_accumulator.sv
// -----------------------------------------------------------------------------
// fp_accumulator
//   Sums a stream of IEEE-754 single operands into one running total, with a
//   per-element add/subtract select. The floating-point adder lives outside:
//   this block drives its operands (add_a/add_b) and registers its sum (add_s)
//   once per accepted element. The total is returned on a valid/ready port.
//
//   Parameters:
//     CNT_W      element counter width; out_count saturates at 2**CNT_W-1
//
//   Ports:
//     clk        in   1      clock, rising edge
//     rst_n      in   1      asynchronous active-low reset
//     flush      in   1      synchronous abort back to IDLE
//     in_valid   in   1      input element valid
//     in_ready   out  1      element can be accepted this cycle
//     in_data    in   32     IEEE-754 single operand
//     in_sub     in   1      subtract in_data (sign bit inverted)
//     in_last    in   1      element closes the vector
//     add_a      out  32     to fp_adder.a (accumulator)
//     add_b      out  32     to fp_adder.b (signed operand)
//     add_s      in   32     from fp_adder.s (combinational sum)
//     out_valid  out  1      result valid
//     out_ready  in   1      consumer takes result
//     out_sum    out  32     vector total
//     out_count  out  CNT_W  elements accepted in the vector (saturating)
//     exc_flag   out  1      sticky Inf/NaN indicator
//
//   Build option:
//     FPACC_EXC_FLAG_EN  when defined, exc_flag sets on any accepted operand or
//                        sampled adder sum with an all-ones exponent and stays
//                        set until result handshake, flush or reset. When not
//                        defined, exc_flag is tied low and no detector exists.
// -----------------------------------------------------------------------------
module fp_accumulator
  import fpacc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             exc_flag
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_reg;
  logic [31:0]      acc_reg;
  logic [CNT_W-1:0] count_reg;
  logic             out_valid_reg;

  logic [31:0]      signed_data;
  logic             accept;
  logic             handshake;

  // Subtraction is a plain sign flip, so it also works for the first element
  // where the adder is bypassed (and -0 survives).
  assign signed_data = in_data ^ (in_sub ? SIGN_MASK : 32'h0);

  assign in_ready  = (state_reg != DONE) && !flush;
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_reg && out_ready;

  assign add_a = acc_reg;
  assign add_b = signed_data;

  assign out_valid = out_valid_reg;
  assign out_sum   = acc_reg;
  assign out_count = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= 32'h0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else if (flush) begin
      state_reg     <= IDLE;
      acc_reg       <= 32'h0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            // First element loads directly: no adder round-trip, sign kept.
            acc_reg   <= signed_data;
            count_reg <= CNT_ONE;
            if (in_last) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end else begin
              state_reg <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_reg <= add_s;
            if (count_reg != CNT_MAX) begin
              count_reg <= count_reg + CNT_ONE;
            end
            if (in_last) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          // No bypass: a new vector can only start the cycle after handshake.
          if (out_ready) begin
            state_reg     <= IDLE;
            acc_reg       <= 32'h0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          acc_reg       <= 32'h0;
          count_reg     <= '0;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef FPACC_EXC_FLAG_EN
  logic exc_reg;
  logic op_exc;
  logic sum_exc;

  fpacc_exc_det u_op_det (
    .value  (signed_data),
    .is_exc (op_exc)
  );

  fpacc_exc_det u_sum_det (
    .value  (add_s),
    .is_exc (sum_exc)
  );

  // add_s only counts when it is actually sampled, i.e. an ACCUM accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_reg <= 1'b0;
    end else if (flush || handshake) begin
      exc_reg <= 1'b0;
    end else if (accept && (op_exc || ((state_reg == ACCUM) && sum_exc))) begin
      exc_reg <= 1'b1;
    end
  end

  assign exc_flag = exc_reg;
`else
  assign exc_flag = 1'b0;
`endif

endmodule

// File: tb/tb_fp_accumulator.sv
// -----------------------------------------------------------------------------
// tb_fp_accumulator
//   Directed bench for fp_accumulator. A behavioural single-precision adder
//   (through double-precision reals; exact for the values used here) stands in
//   for fp_adder on add_a/add_b/add_s.
// -----------------------------------------------------------------------------
module tb_fp_accumulator;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_sub;
  logic             in_last;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_s;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic             exc_flag;

  int checks = 0;
  int errors = 0;

`ifdef FPACC_EXC_FLAG_EN
  localparam logic [31:0] EXC_EXP = 32'd1;
`else
  localparam logic [31:0] EXC_EXP = 32'd0;
`endif

  fp_accumulator #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .exc_flag  (exc_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- behavioural adder model ----
  function automatic real sp2real(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:23] == 8'h00) begin
      d = {f[31], 63'b0};
    end else if (f[30:23] == 8'hFF) begin
      d = {f[31], 11'h7FF, f[22:0], 29'b0};
    end else begin
      e = 11'(f[30:23]) + 11'd896;
      d = {f[31], e, f[22:0], 29'b0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 2047) begin
      return {d[63], 8'hFF, (d[51:29] != 23'h0 || d[51:0] != 52'h0) ? (d[51:29] | 23'h400000) : 23'h0};
    end else if (e - 896 <= 0) begin
      return {d[63], 31'b0};
    end else if (e - 896 >= 255) begin
      return {d[63], 8'hFF, 23'h0};
    end
    return {d[63], 8'(e - 896), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return real2sp(sp2real(a) + sp2real(b));
  endfunction

  assign add_s = fadd(add_a, add_b);

  // ---- checking ----
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  // Present one element; waits (bounded) for in_ready, then consumes one edge.
  task automatic send(input logic [31:0] d, input logic s, input logic l);
    int n;
    n = 0;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sub   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] sum, input logic [31:0] cnt);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   out_sum, sum);
    check({tag, "_count"}, 32'(out_count), cnt);
    $display("result %s: sum=%08h count=%0d", tag, out_sum, out_count);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_count"}, 32'(out_count), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_sum",   out_sum, 32'h0);
    check("rst_exc",   32'(exc_flag), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1) 1.0 + 2.0
    send(32'h3f800000, 1'b0, 1'b0);
    check("t1_mid_valid", 32'(out_valid), 32'd0);
    send(32'h40000000, 1'b0, 1'b1);
    expect_result("t1", 32'h40400000, 32'd2);
    handshake("t1");

    // 2) 1.0 - 1.0, single subtracted element, -0 preserved
    send(32'h3f800000, 1'b0, 1'b0);
    send(32'h3f800000, 1'b1, 1'b1);
    expect_result("t2a", 32'h00000000, 32'd2);
    handshake("t2a");
    send(32'h40000000, 1'b1, 1'b1);
    expect_result("t2b", 32'hc0000000, 32'd1);
    handshake("t2b");
    send(32'h00000000, 1'b1, 1'b1);
    expect_result("t2c", 32'h80000000, 32'd1);
    handshake("t2c");

    // 3) backpressure: 1.0 + 3.0 held for 5 cycles
    send(32'h3f800000, 1'b0, 1'b0);
    send(32'h40400000, 1'b0, 1'b1);
    in_data  = 32'h41200000;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_ready", 32'(in_ready), 32'd0);
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_sum",   out_sum, 32'h40800000);
      check("t3_hold_count", 32'(out_count), 32'd2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_result("t3", 32'h40800000, 32'd2);
    handshake("t3");
    send(32'h3f800000, 1'b0, 1'b1);
    expect_result("t3_next", 32'h3f800000, 32'd1);
    handshake("t3_next");

    // 4) flush after 3 of 5 elements
    for (int i = 0; i < 3; i++) send(32'h3f800000, 1'b0, 1'b0);
    check("t4_pre_count", 32'(out_count), 32'd3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h3f800000;
    #1;
    check("t4_flush_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t4_no_valid", 32'(out_valid), 32'd0);
      check("t4_count", 32'(out_count), 32'd0);
      check("t4_sum", out_sum, 32'h0);
      @(posedge clk); #1;
    end
    send(32'h3f800000, 1'b0, 1'b1);
    expect_result("t4_next", 32'h3f800000, 32'd1);
    handshake("t4_next");

    // 5) +Inf + -Inf -> NaN, exception flag
    send(32'h7f800000, 1'b0, 1'b0);
    check("t5_exc_first", 32'(exc_flag), EXC_EXP);
    send(32'hff800000, 1'b0, 1'b1);
    check("t5_valid", 32'(out_valid), 32'd1);
    check("t5_is_nan", 32'(out_sum[30:23] == 8'hFF && out_sum[22:0] != 23'h0), 32'd1);
    check("t5_count", 32'(out_count), 32'd2);
    check("t5_exc_done", 32'(exc_flag), EXC_EXP);
    $display("result t5: sum=%08h count=%0d exc=%0d", out_sum, out_count, exc_flag);
    handshake("t5");
    check("t5_exc_clear", 32'(exc_flag), 32'd0);

    // 6) 300 x 1.0: count saturates, sum keeps going
    for (int i = 0; i < 300; i++) send(32'h3f800000, 1'b0, (i == 299));
    expect_result("t6", 32'h43960000, 32'd255);
    handshake("t6");

    // 6b) asynchronous reset mid-vector
    for (int i = 0; i < 3; i++) send(32'h40000000, 1'b0, 1'b0);
    check("t6b_pre_sum", out_sum, 32'h40c00000);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6b_rst_valid", 32'(out_valid), 32'd0);
    check("t6b_rst_count", 32'(out_count), 32'd0);
    check("t6b_rst_sum",   out_sum, 32'h0);
    check("t6b_rst_exc",   32'(exc_flag), 32'd0);
    check("t6b_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h40000000, 1'b0, 1'b1);
    expect_result("t6b_next", 32'h40000000, 32'd1);
    handshake("t6b_next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
